// File: rtl/event_counter_bank_if.sv
// EVENT_INT bundle: one pulse per core event per cycle.
// The execute/control path drives the `out` side; the counter bank consumes the `in` side.
interface event_int;
    logic execute;
    logic load;
    logic store;
    logic unaligned;
    logic arithmetic;
    logic trap;
    logic interrupt;
    logic conditional_branch;
    logic unconditional_branch;
    logic branch;

    modport out (
        output execute, load, store, unaligned, arithmetic,
               trap, interrupt, conditional_branch, unconditional_branch, branch
    );

    modport in (
        input  execute, load, store, unaligned, arithmetic,
               trap, interrupt, conditional_branch, unconditional_branch, branch
    );
endinterface

// File: rtl/event_counter_bank.sv
// event_counter_bank: machine-mode performance counter bank.
// Counter slots 0 (mcycle), 2 (minstret) and 3..11 (hpm3..hpm11); slot 1 does not exist.
// CSR map: lo half at 0xB00+n, hi half at 0xB80+n, mcountinhibit at 0x320.
// Reads and writes are acknowledged one cycle after the strobe; read data is the
// pre-edge counter value. A CSR write to a counter beats that cycle's increment.
// Optional feature macro EVENT_OVF_IRQ_EN: adds the W1C wrap register mhpmovf at 0x7C0
// and the registered ovf_irq output (OR of mhpmovf). Without it, wraps are silent and
// 0x7C0 is unmapped.
module event_counter_bank #(
    parameter int CNT_W  = 64,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    event_int.in        events,
    input  logic [11:0] csr_addr,
    input  logic        csr_rd,
    input  logic        csr_wr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_ack,
    output logic        csr_illegal
`ifdef EVENT_OVF_IRQ_EN
    ,
    output logic        ovf_irq
`endif
);

    localparam int          N_CNT    = 12;
    localparam int          HI_W     = CNT_W - 32;
    // Slots that physically exist (slot 1 is a hole in the architectural numbering).
    localparam logic [11:0] CNT_MASK = 12'hFFD;

    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("event_counter_bank: RD_LAT must be 1");
    end
    if (CNT_W < 33 || CNT_W > 64) begin : g_bad_cnt_w
        $error("event_counter_bank: CNT_W must be in 33..64");
    end

    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [11:0]      inhibit_q;
    logic [11:0]      ev;
    logic [11:0]      inc;
    logic [11:0]      lo_hit;
    logic [11:0]      hi_hit;
    logic             inh_hit;
    logic             ovf_hit;
    logic             mapped;
    logic [31:0]      rd_value;

    // Event vector indexed by counter slot: cycle always counts, slot 1 never does.
    assign ev = {events.branch, events.unconditional_branch, events.conditional_branch,
                 events.interrupt, events.trap, events.arithmetic, events.unaligned,
                 events.store, events.load, events.execute, 1'b0, 1'b1};

    // Per-slot increment request, gated by mcountinhibit.
    assign inc = ev & ~inhibit_q & CNT_MASK;

`ifdef EVENT_OVF_IRQ_EN
    logic [11:0] ovf_q;
    logic [11:0] wrap;

    // A slot wraps when it increments from all-ones and is not being overwritten.
    always_comb begin
        wrap = '0;
        for (int i = 0; i < N_CNT; i++) begin
            wrap[i] = inc[i] && (&cnt_q[i]) && !(csr_wr && (lo_hit[i] || hi_hit[i]));
        end
    end

    assign ovf_hit = (csr_addr == 12'h7C0);
`else
    assign ovf_hit = 1'b0;
`endif

    // CSR address decode and read-data mux, sampled from pre-edge state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        lo_hit   = '0;
        hi_hit   = '0;
        rd_value = '0;
        inh_hit  = (csr_addr == 12'h320);
        for (int i = 0; i < N_CNT; i++) begin
            if (CNT_MASK[i]) begin
                lo_hit[i] = (csr_addr == 12'hB00 + 12'(i));
                hi_hit[i] = (csr_addr == 12'hB80 + 12'(i));
            end
            if (lo_hit[i]) rd_value = cnt_q[i][31:0];
            if (hi_hit[i]) rd_value[HI_W-1:0] = cnt_q[i][CNT_W-1:32];
        end
        if (inh_hit) rd_value = {20'h0, inhibit_q};
`ifdef EVENT_OVF_IRQ_EN
        if (ovf_hit) rd_value = {20'h0, ovf_q};
`endif
        mapped = (|lo_hit) || (|hi_hit) || inh_hit || ovf_hit;
    end

    // Counter and mcountinhibit state: CSR write wins over the same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the counter array is architectural state that must read 0 after reset,
            // so every entry is cleared explicitly rather than left as uninitialised storage.
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            inhibit_q <= '0;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
                if (csr_wr && lo_hit[i]) begin
                    cnt_q[i][31:0] <= csr_wdata;
                end else if (csr_wr && hi_hit[i]) begin
                    cnt_q[i][CNT_W-1:32] <= csr_wdata[HI_W-1:0];
                end else if (inc[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            if (csr_wr && inh_hit) begin
                inhibit_q <= csr_wdata[11:0] & CNT_MASK;
            end
        end
    end

`ifdef EVENT_OVF_IRQ_EN
    // Wrap flags: W1C from the CSR port, a same-cycle wrap wins; interrupt is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q   <= '0;
            ovf_irq <= 1'b0;
        end else begin
            ovf_q   <= (ovf_q & ~((csr_wr && ovf_hit) ? csr_wdata[11:0] : 12'h0)) | wrap;
            ovf_irq <= |ovf_q;
        end
    end
`endif

    // Registered CSR response: ack one cycle after any strobe, zeros otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rdata   <= '0;
            csr_ack     <= 1'b0;
            csr_illegal <= 1'b0;
        end else begin
            csr_ack     <= csr_rd || csr_wr;
            csr_illegal <= (csr_rd || csr_wr) && !mapped;
            csr_rdata   <= csr_rd ? rd_value : 32'h0;
        end
    end

endmodule

// File: tb/tb_event_counter_bank.sv
// Scoreboard bench for event_counter_bank (default CNT_W = 64).
// The driver issues one cycle of stimulus at a time, updates a behavioural model of the
// counter bank and queues the expected CSR response; the monitor compares DUT outputs
// one step after each rising edge. Directed scenarios come first, then random traffic.
module tb_event_counter_bank;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        illegal;
    } exp_t;

    localparam logic [11:0] EV_EXEC  = 12'h004;
    localparam logic [11:0] EV_LOAD  = 12'h008;
    localparam logic [11:0] EV_STORE = 12'h010;
    localparam logic [11:0] EV_TRAP  = 12'h080;
    localparam logic [11:0] ADDR_POOL [16] = '{
        12'hB00, 12'hB02, 12'hB03, 12'hB05, 12'hB07, 12'hB0B, 12'hB80, 12'hB82,
        12'hB84, 12'hB8B, 12'h320, 12'h7C0, 12'hB01, 12'hB81, 12'hB0C, 12'h000
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] csr_addr = '0;
    logic        csr_rd = 1'b0;
    logic        csr_wr = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_ack;
    logic        csr_illegal;
`ifdef EVENT_OVF_IRQ_EN
    logic        ovf_irq;
`endif

    event_int ev_if ();

    event_counter_bank dut (
        .clk         (clk),
        .rst         (rst),
        .events      (ev_if),
        .csr_addr    (csr_addr),
        .csr_rd      (csr_rd),
        .csr_wr      (csr_wr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_ack     (csr_ack),
        .csr_illegal (csr_illegal)
`ifdef EVENT_OVF_IRQ_EN
        ,
        .ovf_irq     (ovf_irq)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [63:0] m_cnt [12];
    logic [11:0] m_inh;
    logic [11:0] m_ovf;

    exp_t exp_q [$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Counter slot addressed by a CSR address, or -1 when it is not a counter.
    function automatic int cnt_idx(input logic [11:0] a);
        if (a >= 12'hB00 && a <= 12'hB0B && a != 12'hB01) return int'(a - 12'hB00);
        if (a >= 12'hB80 && a <= 12'hB8B && a != 12'hB81) return int'(a - 12'hB80);
        return -1;
    endfunction

    function automatic bit model_mapped(input logic [11:0] a);
        if (cnt_idx(a) >= 0 || a == 12'h320) return 1'b1;
`ifdef EVENT_OVF_IRQ_EN
        if (a == 12'h7C0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int i;
        i = cnt_idx(a);
        if (i >= 0) return a[7] ? m_cnt[i][63:32] : m_cnt[i][31:0];
        if (a == 12'h320) return {20'h0, m_inh};
`ifdef EVENT_OVF_IRQ_EN
        if (a == 12'h7C0) return {20'h0, m_ovf};
`endif
        return 32'h0;
    endfunction

    // One clock cycle of stimulus; optionally the expected read data is a fixed constant.
    task automatic drive(input logic r, input logic rd, input logic wr,
                         input logic [11:0] addr, input logic [31:0] wd, input logic [11:0] ev,
                         input bit use_k, input logic [31:0] k_data, input logic k_ill);
        exp_t        e;
        int          wi;
        logic [11:0] ovf_set;
        @(negedge clk);
        rst       = r;
        csr_rd    = rd;
        csr_wr    = wr;
        csr_addr  = addr;
        csr_wdata = wd;
        ev_if.execute              = ev[2];
        ev_if.load                 = ev[3];
        ev_if.store                = ev[4];
        ev_if.unaligned            = ev[5];
        ev_if.arithmetic           = ev[6];
        ev_if.trap                 = ev[7];
        ev_if.interrupt            = ev[8];
        ev_if.conditional_branch   = ev[9];
        ev_if.unconditional_branch = ev[10];
        ev_if.branch               = ev[11];
        if (r) begin
            for (int i = 0; i < 12; i++) m_cnt[i] = '0;
            m_inh = '0;
            m_ovf = '0;
        end else begin
            if (rd || wr) begin
                e.due     = cyc + 1;
                e.rdata   = use_k ? k_data : (rd ? model_read(addr) : 32'h0);
                e.illegal = use_k ? k_ill : !model_mapped(addr);
                exp_q.push_back(e);
            end
            wi      = wr ? cnt_idx(addr) : -1;
            ovf_set = '0;
            for (int i = 0; i < 12; i++) begin
                if (i != 1 && i != wi && (i == 0 || ev[i]) && !m_inh[i]) begin
                    if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) ovf_set[i] = 1'b1;
                    m_cnt[i] = m_cnt[i] + 64'd1;
                end
            end
            if (wi >= 0) begin
                if (addr[7]) m_cnt[wi][63:32] = wd;
                else         m_cnt[wi][31:0]  = wd;
            end
            if (wr && addr == 12'h320) m_inh = wd[11:0] & 12'hFFD;
            if (wr && addr == 12'h7C0) m_ovf = m_ovf & ~wd[11:0];
            m_ovf = m_ovf | ovf_set;
        end
    endtask

    task automatic idle(input logic [11:0] ev);
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, ev, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wr_csr(input logic [11:0] addr, input logic [31:0] wd, input logic [11:0] ev);
        drive(1'b0, 1'b0, 1'b1, addr, wd, ev, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd_chk(input logic [11:0] addr, input logic [31:0] k, input logic k_ill);
        drive(1'b0, 1'b1, 1'b0, addr, 32'h0, 12'h0, 1'b1, k, k_ill);
    endtask

    // Monitor: after each rising edge, compare against the queued response or idle zeros.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                check("ack_missed", 32'(cyc), 32'(e.due));
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("ack", 32'(csr_ack), 32'h1);
                check("rdata", csr_rdata, e.rdata);
                check("illegal", 32'(csr_illegal), 32'(e.illegal));
            end else begin
                check("idle_ack", 32'(csr_ack), 32'h0);
                check("idle_rdata", csr_rdata, 32'h0);
                check("idle_illegal", 32'(csr_illegal), 32'h0);
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        logic [11:0] a;
        logic [31:0] wd;
        ev_if.execute = 1'b0; ev_if.load = 1'b0; ev_if.store = 1'b0;
        ev_if.unaligned = 1'b0; ev_if.arithmetic = 1'b0; ev_if.trap = 1'b0;
        ev_if.interrupt = 1'b0; ev_if.conditional_branch = 1'b0;
        ev_if.unconditional_branch = 1'b0; ev_if.branch = 1'b0;

        // Reset with events and a strobe present: nothing counted, nothing acked.
        drive(1'b1, 1'b1, 1'b0, 12'hB03, 32'h0, 12'hFFC, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 12'hFFC, 1'b0, 32'h0, 1'b0);

        // Five load pulses.
        repeat (5) idle(EV_LOAD);
        rd_chk(12'hB03, 32'd5, 1'b0);

        // hpm4 wraps from all-ones to zero.
        wr_csr(12'hB04, 32'hFFFF_FFFF, 12'h0);
        wr_csr(12'hB84, 32'hFFFF_FFFF, 12'h0);
        idle(EV_STORE);
        rd_chk(12'hB04, 32'h0, 1'b0);
        rd_chk(12'hB84, 32'h0, 1'b0);
`ifdef EVENT_OVF_IRQ_EN
        rd_chk(12'h7C0, 32'h10, 1'b0);
        idle(12'h0);
        @(posedge clk);
        #1;
        check("ovf_irq_set", 32'(ovf_irq), 32'h1);
        wr_csr(12'h7C0, 32'h10, 12'h0);
        rd_chk(12'h7C0, 32'h0, 1'b0);
`endif

        // Inhibit minstret, then release it.
        wr_csr(12'h320, 32'h4, 12'h0);
        repeat (3) idle(EV_EXEC);
        rd_chk(12'hB02, 32'd0, 1'b0);
        wr_csr(12'h320, 32'h0, 12'h0);
        repeat (2) idle(EV_EXEC);
        rd_chk(12'hB02, 32'd2, 1'b0);

        // Write beats the same-cycle increment.
        wr_csr(12'hB07, 32'd100, EV_TRAP);
        idle(EV_TRAP);
        rd_chk(12'hB07, 32'd101, 1'b0);

        // Unmapped read, and mcountinhibit reserved bits.
        rd_chk(12'hB0C, 32'h0, 1'b1);
        wr_csr(12'h320, 32'hFFFF_FFFF, 12'h0);
        rd_chk(12'h320, 32'h0000_0FFD, 1'b0);
        wr_csr(12'h320, 32'h0, 12'h0);

        // Reset in the middle of a back-to-back read burst.
        wr_csr(12'hB05, 32'd7, 12'h0);
        rd_chk(12'hB05, 32'd7, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 12'hB05, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0);
        rd_chk(12'hB05, 32'd0, 1'b0);
        rd_chk(12'hB00, 32'd1, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            a = ADDR_POOL[$urandom_range(0, 15)];
            if (a == 12'h000) a = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       wd = 32'hFFFF_FFFF;
                1:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: wd = $urandom;
            endcase
            if (a == 12'h320 && $urandom_range(0, 1) == 0) wd = 32'h0;
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) < 3), a, wd, 12'($urandom), 1'b0, 32'h0, 1'b0);
        end

        repeat (3) idle(12'h0);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
